// File: rtl/synth_pkg.sv
// Shared synth-voice definitions: envelope state encoding, default widths
// and the envelope full-scale constant.
package synth_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int ENV_W_DEF    = 16;

  // Full-scale envelope level for the default width.
  localparam logic [ENV_W_DEF-1:0] ENV_MAX = {ENV_W_DEF{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/env_vca.sv
// Envelope VCA stage: captures the oscillator sample on a tick, then on the
// following edge registers signed(sample) x unsigned(level), keeping the
// upper SAMPLE_W bits of the product (arithmetic truncation).
//
// Handshake: out_valid is a one-cycle qualifier with no ready/backpressure.
// sample_out is a new result only in the cycle out_valid is high; the
// downstream codec interface must take it in that cycle.
module env_vca #(
  parameter int SAMPLE_W = 16,
  parameter int ENV_W    = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       sample_tick,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic        [ENV_W-1:0]    env_level,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       out_valid
);

  logic signed [SAMPLE_W-1:0]     cap_sample;
  logic                           cap_valid;
  logic signed [SAMPLE_W+ENV_W:0] product;
  logic                           unused_prod_msb;

  // Level is zero-extended so it multiplies as an unsigned gain.
  assign product         = cap_sample * $signed({1'b0, env_level});
  assign unused_prod_msb = product[SAMPLE_W+ENV_W];

  // Capture the sample alongside the tick that produced the new level.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cap_sample <= '0;
      cap_valid  <= 1'b0;
    end else begin
      cap_valid <= sample_tick;
      if (sample_tick) begin
        cap_sample <= sample_in;
      end
    end
  end

  // Scale the captured sample by the level registered on the tick edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sample_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= cap_valid;
      if (cap_valid) begin
        sample_out <= product[SAMPLE_W+ENV_W-1:ENV_W];
      end
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator and VCA. Advances on sample_tick only;
// key edges are detected against the gate value seen at the previous tick.
// Build option: define ADSR_EXP_RELEASE_EN for exponential release
// (step = max(level >> release_rate[3:0], 1)); otherwise release is linear.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ENV_W    = ENV_W_DEF
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       sample_tick,
  input  logic                       key_on,
  input  logic        [ENV_W-1:0]    attack_rate,
  input  logic        [ENV_W-1:0]    decay_rate,
  input  logic        [ENV_W-1:0]    sustain_level,
  input  logic        [ENV_W-1:0]    release_rate,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       out_valid,
  output logic        [ENV_W-1:0]    env_level,
  output logic        [2:0]          env_state
);

  localparam logic [ENV_W:0] FULL = {1'b0, {ENV_W{1'b1}}};

  env_state_t       state_q, state_d, entry_state;
  logic [ENV_W-1:0] level_q, level_d;
  logic             key_q;
  logic             key_rise, key_fall;
  logic [ENV_W:0]   attack_sum;
  logic [ENV_W:0]   decay_floor;
  logic [ENV_W-1:0] rel_step;

  assign key_rise    = key_on & ~key_q;
  assign key_fall    = ~key_on & key_q;
  assign attack_sum  = {1'b0, level_q} + {1'b0, attack_rate};
  // Decay lands on sustain once level - rate <= sustain, i.e. level <= sustain + rate.
  assign decay_floor = {1'b0, sustain_level} + {1'b0, decay_rate};

`ifdef ADSR_EXP_RELEASE_EN
  logic [ENV_W-1:0] rel_shift;
  logic             unused_rate_hi;
  assign rel_shift      = level_q >> release_rate[3:0];
  assign unused_rate_hi = ^release_rate[ENV_W-1:4];
  // Never step by less than 1 so release always reaches zero.
  assign rel_step       = (rel_shift == '0) ? {{(ENV_W-1){1'b0}}, 1'b1} : rel_shift;
`else
  assign rel_step = release_rate;
`endif

  // State, level and gate history advance only on a sample tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      key_q   <= 1'b0;
    end else if (sample_tick) begin
      state_q <= state_d;
      level_q <= level_d;
      key_q   <= key_on;
    end
  end

  // Gate edges override the current state before its step rule applies.
  always_comb begin
    entry_state = state_q;
    if (key_rise) begin
      entry_state = ST_ATTACK;
    end else if (key_fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                              state_q == ST_SUSTAIN)) begin
      entry_state = ST_RELEASE;
    end
  end

  // Next state: each phase exits once its saturating step hits its target.
  always_comb begin
    state_d = entry_state;
    case (entry_state)
      ST_ATTACK:  if (attack_sum >= FULL)              state_d = ST_DECAY;
      ST_DECAY:   if ({1'b0, level_q} <= decay_floor)  state_d = ST_SUSTAIN;
      ST_SUSTAIN: state_d = ST_SUSTAIN;
      ST_RELEASE: if (level_q <= rel_step)             state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Next level: saturating step of the entry state's rule.
  always_comb begin
    level_d = level_q;
    case (entry_state)
      ST_ATTACK:  level_d = (attack_sum >= FULL) ? FULL[ENV_W-1:0] : attack_sum[ENV_W-1:0];
      ST_DECAY:   level_d = ({1'b0, level_q} <= decay_floor) ? sustain_level
                                                               : level_q - decay_rate;
      ST_SUSTAIN: level_d = sustain_level;
      ST_RELEASE: level_d = (level_q <= rel_step) ? '0 : level_q - rel_step;
      default:    level_d = '0;
    endcase
  end

  // Expose the live envelope state and level.
  always_comb begin
    env_state = state_q;
    env_level = level_q;
  end

  env_vca #(
    .SAMPLE_W (SAMPLE_W),
    .ENV_W    (ENV_W)
  ) u_env_vca (
    .Clk         (Clk),
    .Reset       (Reset),
    .sample_tick (sample_tick),
    .sample_in   (sample_in),
    .env_level   (level_q),
    .sample_out  (sample_out),
    .out_valid   (out_valid)
  );

endmodule
